// File: rtl/petajon_pit_pkg.sv
// petajon_pit_pkg
// Shared definitions for the programmable interval timer: register offsets
// inside a channel window, the two global register addresses, the CTRL bit
// positions and a packed view of the CTRL register.
// Optional feature macro: PETAJON_PIT_CAPTURE_EN (adds CAPSEL/CIE bits).
package petajon_pit_pkg;

   // Offsets inside one 16-byte channel window (adr_i[3:0]).
   localparam logic [3:0] COUNT = 4'h0;
   localparam logic [3:0] MAX   = 4'h4;
   localparam logic [3:0] ONT   = 4'h8;
   localparam logic [3:0] CTRL  = 4'hC;

   // Global registers (full 8-bit address).
   localparam logic [7:0] STAT  = 8'h80;
   localparam logic [7:0] FORCE = 8'h84;

   // CTRL bit positions.
   localparam int CTRL_LOAD   = 0;
   localparam int CTRL_EN     = 1;
   localparam int CTRL_AUTO   = 2;
   localparam int CTRL_GE     = 3;
   localparam int CTRL_IE     = 4;
   localparam int CTRL_CAPSEL = 5;
   localparam int CTRL_CIE    = 6;

   // Packed CTRL register, MSB first so that a cast to 32 bits matches
   // the bit positions above.
   typedef struct packed {
      logic cie;
      logic capSel;
      logic ie;
      logic ge;
      logic autoRl;
      logic en;
      logic load;
   } ctrl_t;

endpackage

// File: rtl/petajon_pit_chan.sv
// petajon_pit_chan
// One timer channel: CW-bit down-counter with reload value (MAX), on-time
// compare (ONT), CTRL register and a one-cycle pending-set pulse.
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   ce, gate              count tick enable and external gate
//   wrMax/wrOnt/wrCtrl    register write strobes, data on wrData
//   rdOfs, rdData         register offset to read and zero-extended result
//   setPend               pulses when the channel wants its pending bit set
//   irqEn                 current IE bit
//   wave                  registered waveform output EN & (count < ONT)
// Optional feature macro: PETAJON_PIT_CAPTURE_EN adds a CAP register that
// latches the count on a rising gate edge.
module petajon_pit_chan
   import petajon_pit_pkg::*;
#(
   parameter int CW = 32
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          ce,
   input  logic          gate,
   input  logic          wrMax,
   input  logic          wrOnt,
   input  logic          wrCtrl,
   input  logic [CW-1:0] wrData,
   input  logic [3:0]    rdOfs,
   output logic [31:0]   rdData,
   output logic          setPend,
   output logic          irqEn,
   output logic          wave
);

   localparam logic [CW-1:0] ONE = CW'(1);

   logic [CW-1:0] countQ, countD;
   logic [CW-1:0] maxQ, maxD;
   logic [CW-1:0] ontQ, ontD;
   ctrl_t         ctrlQ, ctrlD;
   logic          waveQ, waveD;
   logic          tick;
   logic          terminal;
   logic [CW-1:0] countRd;

   // Counter and register update. LOAD beats both decrement and the
   // terminal reload, and suppresses the terminal event. The terminal
   // reload reads maxQ, so a MAX write in the same cycle only affects the
   // following period. A one-shot clears EN itself unless software rewrites
   // CTRL in that very cycle, in which case the written value wins.
   always_comb begin
      countD   = countQ;
      maxD     = maxQ;
      ontD     = ontQ;
      ctrlD    = ctrlQ;
      terminal = 1'b0;
      tick     = ctrlQ.en & ce & (~ctrlQ.ge | gate);

      if (wrCtrl && wrData[CTRL_LOAD]) begin
         countD = maxQ;
      end else if (tick) begin
         if (countQ != '0) begin
            countD = countQ - ONE;
         end else begin
            terminal = 1'b1;
            if (ctrlQ.autoRl) begin
               countD = maxQ;
            end else begin
               ctrlD.en = 1'b0;
            end
         end
      end

      if (wrMax) begin
         maxD = wrData;
      end
      if (wrOnt) begin
         ontD = wrData;
      end
      if (wrCtrl) begin
         ctrlD.load   = 1'b0;
         ctrlD.en     = wrData[CTRL_EN];
         ctrlD.autoRl = wrData[CTRL_AUTO];
         ctrlD.ge     = wrData[CTRL_GE];
         ctrlD.ie     = wrData[CTRL_IE];
`ifdef PETAJON_PIT_CAPTURE_EN
         ctrlD.capSel = wrData[CTRL_CAPSEL];
         ctrlD.cie    = wrData[CTRL_CIE];
`endif
      end

      waveD = ctrlQ.en & (countQ < ontQ);
   end

   // Channel state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         countQ <= '0;
         maxQ   <= '0;
         ontQ   <= '0;
         ctrlQ  <= '0;
         waveQ  <= 1'b0;
      end else begin
         countQ <= countD;
         maxQ   <= maxD;
         ontQ   <= ontD;
         ctrlQ  <= ctrlD;
         waveQ  <= waveD;
      end
   end

`ifdef PETAJON_PIT_CAPTURE_EN
   logic          gatePrevQ;
   logic [CW-1:0] capQ, capD;
   logic          gateRise;

   // Rising-edge detect on the gate against last cycle's copy; the edge
   // snapshots the live count into CAP.
   always_comb begin
      gateRise = gate & ~gatePrevQ;
      capD     = gateRise ? countQ : capQ;
   end

   // Capture registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         gatePrevQ <= 1'b0;
         capQ      <= '0;
      end else begin
         gatePrevQ <= gate;
         capQ      <= capD;
      end
   end

   assign setPend = terminal | (gateRise & ctrlQ.cie);
   assign countRd = ctrlQ.capSel ? capQ : countQ;
`else
   assign setPend = terminal;
   assign countRd = countQ;
`endif

   // Register read selection, zero-extended to the bus width. LOAD is never
   // stored, so CTRL bit 0 always reads back 0.
   always_comb begin
      rdData = '0;
      case (rdOfs)
         COUNT:   rdData = 32'(countRd);
         MAX:     rdData = 32'(maxQ);
         ONT:     rdData = 32'(ontQ);
         CTRL:    rdData = 32'(ctrlQ);
         default: rdData = '0;
      endcase
   end

   assign irqEn = ctrlQ.ie;
   assign wave  = waveQ;

endmodule

// File: rtl/petajon_pit.sv
// petajon_pit
// Programmable interval timer with NCH channels on the cs/cyc/stb/ack I/O
// bus. Holds the bus decode, STAT/FORCE pending logic, read mux and the
// registered interrupt outputs; each channel lives in petajon_pit_chan.
// Ports:
//   clk_i, rst_i           clock and synchronous active-high reset
//   cs_i, cyc_i, stb_i     bus select/qualifiers
//   wr_i, adr_i, dat_i     write enable, address, write data
//   ack_o, dat_o, vol_o    acknowledge, registered read data, volatile flag
//   ce_i                   count tick enable
//   gate_i                 per-channel gate
//   out_o                  per-channel waveform
//   irq_o                  per-channel level interrupt request
// Optional feature macro: PETAJON_PIT_CAPTURE_EN (gate-edge capture).
module petajon_pit
   import petajon_pit_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = 32
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           cs_i,
   input  logic           cyc_i,
   input  logic           stb_i,
   output logic           ack_o,
   input  logic           wr_i,
   input  logic [7:0]     adr_i,
   input  logic [31:0]    dat_i,
   output logic [31:0]    dat_o,
   output logic           vol_o,
   input  logic           ce_i,
   input  logic [NCH-1:0] gate_i,
   output logic [NCH-1:0] out_o,
   output logic [NCH-1:0] irq_o
);

   logic           cs;
   logic           csWr;
   logic           rdyQ, rdyD;
   logic [31:0]    datQ, datD;
   logic [31:0]    rdMux;
   logic [NCH-1:0] pendingQ, pendingD;
   logic [NCH-1:0] irqQ, irqD;
   logic [NCH-1:0] forceSet, statClr;
   logic [NCH-1:0] termSet, ieVec, waveVec;
   logic [NCH-1:0] wrMaxV, wrOntV, wrCtrlV;
   logic [31:0]    chanRd [NCH];

   assign cs    = cs_i & cyc_i & stb_i;
   assign csWr  = cs & wr_i;
   assign vol_o = cs;
   assign ack_o = csWr | rdyQ;
   assign dat_o = datQ;
   assign out_o = waveVec;
   assign irq_o = irqQ;

   // One channel per index; write strobes decode window, channel number
   // and exact aligned offset, so channels >= NCH simply never match.
   for (genvar i = 0; i < NCH; i++) begin : g_chan
      assign wrMaxV[i]  = csWr & ~adr_i[7] & (adr_i[6:4] == 3'(i)) & (adr_i[3:0] == MAX);
      assign wrOntV[i]  = csWr & ~adr_i[7] & (adr_i[6:4] == 3'(i)) & (adr_i[3:0] == ONT);
      assign wrCtrlV[i] = csWr & ~adr_i[7] & (adr_i[6:4] == 3'(i)) & (adr_i[3:0] == CTRL);

      petajon_pit_chan #(
         .CW(CW)
      ) u_chan (
         .clock   (clk_i),
         .reset   (rst_i),
         .ce      (ce_i),
         .gate    (gate_i[i]),
         .wrMax   (wrMaxV[i]),
         .wrOnt   (wrOntV[i]),
         .wrCtrl  (wrCtrlV[i]),
         .wrData  (dat_i[CW-1:0]),
         .rdOfs   (adr_i[3:0]),
         .rdData  (chanRd[i]),
         .setPend (termSet[i]),
         .irqEn   (ieVec[i]),
         .wave    (waveVec[i])
      );
   end

   // Read mux: channel window below 0x80, STAT above; anything else,
   // including unimplemented channels, reads zero.
   always_comb begin
      rdMux = '0;
      if (!adr_i[7]) begin
         for (int n = 0; n < NCH; n++) begin
            if (adr_i[6:4] == 3'(n)) begin
               rdMux = chanRd[n];
            end
         end
      end else if (adr_i == STAT) begin
         rdMux[NCH-1:0] = pendingQ;
      end
   end

   // Pending bits: write-1-to-clear from STAT, set by FORCE or a channel
   // event; setting is applied last so a same-cycle event survives a clear.
   // Reads get one registered ready cycle, which drops after one ack so a
   // held strobe does not see a run of acks.
   always_comb begin
      forceSet = '0;
      statClr  = '0;
      if (csWr && (adr_i == FORCE)) begin
         for (int n = 0; n < NCH; n++) begin
            if (dat_i[2:0] == 3'(n)) begin
               forceSet[n] = 1'b1;
            end
         end
      end
      if (csWr && (adr_i == STAT)) begin
         statClr = dat_i[NCH-1:0];
      end
      pendingD = (pendingQ & ~statClr) | termSet | forceSet;
      irqD     = pendingQ & ieVec;
      rdyD     = cs & ~wr_i & ~rdyQ;
      datD     = (cs && !wr_i) ? rdMux : '0;
   end

   // Bus and interrupt state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pendingQ <= '0;
         irqQ     <= '0;
         rdyQ     <= 1'b0;
         datQ     <= '0;
      end else begin
         pendingQ <= pendingD;
         irqQ     <= irqD;
         rdyQ     <= rdyD;
         datQ     <= datD;
      end
   end

endmodule

// File: doc/petajon_pit.md
Name: petajon_pit

Overview:
Programmable interval timer that generates periodic and one-shot interrupt requests for the interrupt controller.
Each channel has a 32-bit down-counter, a reload value, an on-time compare and a pending flag.
Each channel's level irq_o bit wires directly to one controller input (i1..i31); that input is normally configured level-sensitive there.
Sits on the same I/O bus as the interrupt controller and uses the same cs/cyc/stb/ack protocol.

Parameters:
NCH, 4, number of timer channels (1..8).
CW, 32, counter/reload/on-time width in bits (8..32); register reads zero-extend to 32 bits.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
cs_i  in  1  device select
cyc_i  in  1  bus cycle valid
stb_i  in  1  bus strobe
ack_o  out  1  transfer acknowledge
wr_i  in  1  write enable
adr_i  in  8  register address
dat_i  in  32  write data
dat_o  out  32  read data
vol_o  out  1  volatile register selected (= cs)
ce_i  in  1  count tick enable (prescaled timebase); 1 = count this cycle
gate_i  in  NCH  per-channel external gate
out_o  out  NCH  per-channel waveform output
irq_o  out  NCH  per-channel interrupt request (level)

Behaviour:
- Bus qualifier: cs = cs_i & cyc_i & stb_i.
- ack_o: writes ack combinationally when cs is high; reads ack one cycle after cs via registered rdy.
- dat_o: registered; 0 when cs is low.
- Address map:
  - adr_i[7]=0: channel n = adr_i[6:4]; n >= NCH reads 0 and ignores writes.
  - Channel offset 0x0 COUNT: read-only; returns the count sampled at the cs edge.
  - Channel offset 0x4 MAX: read/write reload value.
  - Channel offset 0x8 ONT: read/write on-time.
  - Channel offset 0xC CTRL: bit0 LOAD (self-clearing, reads 0), bit1 EN, bit2 AUTO (auto-reload), bit3 GE (gate enable), bit4 IE (irq enable).
  - 0x80 STAT: read returns pending[NCH-1:0]; write-1-to-clear.
  - 0x84 FORCE: write sets pending[dat_i[2:0]]; values >= NCH are ignored.
- Reset values:
  - count, MAX, ONT, CTRL, pending: all 0.
  - dat_o, ack-pipeline rdy, out_o, irq_o: 0.
- Count condition per channel: EN & ce_i & (~GE | gate_i[n]).
- When counting and count != 0: count <= count - 1.
- When counting and count == 0:
  - Set pending[n].
  - AUTO=1: count <= MAX.
  - AUTO=0: count stays 0 and EN is cleared (one-shot complete).
- MAX == 0 with AUTO=1: pending is set on every counting tick (divide-by-1). No wrap below 0 is allowed.
- LOAD written as 1: count <= MAX on the next edge. LOAD takes priority over decrement and terminal reload in that same cycle; the terminal event is suppressed.
- Simultaneous MAX write and terminal reload: the reload uses the pre-write MAX (register value before the edge).
- Simultaneous STAT clear and new terminal event on the same channel: set wins, so pending stays 1.
- out_o[n] = EN & (count < ONT), registered, one-cycle latency from count. ONT=0 means out_o stays 0.
- irq_o[n] = pending[n] & IE, registered. Clearing IE masks the output but keeps pending.
- Reset asserted mid-count: all state returns to reset values on that edge; no irq is emitted.

Optional Feature:
PETAJON_PIT_CAPTURE_EN
- Defined:
  - Each channel gains a CAP register at channel offset 0x0 with adr_i[3]... remapped: CAP is read at 0x0 when CTRL bit5 CAPSEL=1.
  - CAP latches count on a rising edge of gate_i[n]; the edge is detected with a registered copy of gate_i.
  - The capture sets pending[n] when CTRL bit6 CIE=1.
- Undefined: no capture logic; CTRL bits 5–6 read 0 and writes to them are ignored.

Decomposition:
- Package petajon_pit_pkg holds:
  - Register offset localparams: COUNT, MAX, ONT, CTRL, STAT, FORCE.
  - CTRL bit-index constants.
  - A packed ctrl_t struct.
- Natural sub-module: petajon_pit_chan, one counter channel (count, MAX, ONT, CTRL, terminal/pending-set output). The top module instantiates NCH of them plus the bus decode, STAT/FORCE logic and the read mux.

Test Plan:
- Periodic: ch0 MAX=4, AUTO=1, EN=1, IE=1, ce_i=1 continuously → pending[0] and irq_o[0] rise every 5 ce ticks. Write 0x80 with 1 → irq_o[0] drops 1 cycle later.
- One-shot with ONT: ch1 MAX=9, ONT=3, AUTO=0, LOAD+EN → out_o[1] high for counts 2,1,0. pending[1] set once, EN reads 0 afterwards, count holds 0.
- Gating: ch2 GE=1, gate_i[2] low for 10 cycles then high → COUNT unchanged while the gate is low, then decrements each ce tick.
- Collisions:
  - STAT clear in the same cycle as ch0 terminal → STAT reads 1.
  - MAX write 7 on the terminal cycle with old MAX 4 → reload to 4, next period uses 7.
- Bus protocol: read cycle → ack_o one cycle after cs with valid dat_o. Write → ack_o same cycle. Access to channel 5 with NCH=4 → reads 0x00000000. FORCE dat_i=2 → irq_o[2]=1 when IE=1.
- Reset mid-operation: rst_i pulsed while ch0 count=2 with pending=1 → next cycle all count/pending/irq_o/out_o are 0 and no further irq occurs until reprogrammed.
